sram_test_seq: RTL and testbench

SRAM_TEST_SEQ -- requirements
Module: sram_test_seq

---
 rtl/sram_test_pkg.sv | 28 ++
 rtl/sram_lfsr16.sv | 31 +++
 rtl/sram_test_seq.sv | 168 ++++++++++++++++
 tb/tb_sram_test_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_test_pkg.sv
// sram_test_pkg: shared widths, state encoding and helpers for the SRAM pattern tester.
`default_nettype none

package sram_test_pkg;

   localparam int ADDR_W = 18;
   localparam int DATA_W = 16;
   localparam int RD_LAT = 3;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
   localparam logic [DATA_W-1:0] LFSR_TAPS    = 16'hB400;
   localparam logic [DATA_W-1:0] SEED_DEFAULT = 16'hACE1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WR    = 3'd1,
      RD    = 3'd2,
      DRAIN = 3'd3,
      FIN   = 3'd4
   } state_e;

   function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
      return (&v) ? v : v + ADDR_W'(1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sram_lfsr16.sv
// sram_lfsr16: 16-bit Fibonacci LFSR pattern generator with load (priority) and step.
`default_nettype none

module sram_lfsr16
   import sram_test_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [DATA_W-1:0] seed_i,
   output logic [DATA_W-1:0] q_o
);

   logic [DATA_W-1:0] q_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else if (load_i) begin
         q_q <= seed_i;
      end else if (step_i) begin
         q_q <= {q_q[DATA_W-2:0], ^(q_q & LFSR_TAPS)};
      end
   end

   assign q_o = q_q;

endmodule

`default_nettype wire

// File: rtl/sram_test_seq.sv
// sram_test_seq: writes an LFSR pattern to SRAM, reads it back and counts mismatches.
// Optional first-fail log enabled by defining SRAM_TEST_ERRLOG_EN.
`default_nettype none

module sram_test_seq
   import sram_test_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [DATA_W-1:0] seed_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [ADDR_W-1:0] len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [ADDR_W-1:0] err_cnt_o,
   output logic              mem_o,
   output logic              rw_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_f2s_o,
   input  logic              ready_i,
   input  logic [DATA_W-1:0] data_s2f_r_i,
   output logic [ADDR_W-1:0] fail_addr_o,
   output logic [DATA_W-1:0] fail_exp_o,
   output logic [DATA_W-1:0] fail_act_o
);

   state_e            state_q;
   logic [ADDR_W-1:0] base_q, len_q, idx_q, err_cnt_q, addr_q;
   logic [DATA_W-1:0] seed_q, data_q;
   logic              busy_q, done_q, pass_q, mem_q, rw_q;
   logic [RD_LAT-1:0] tag_v_q;
   logic [DATA_W-1:0] tag_exp_q [RD_LAT];

   logic [DATA_W-1:0] lfsr_q, seed_eff, lfsr_seed;
   logic              accept, last_word, launch, lfsr_load, mismatch;

   assign accept    = mem_q & ready_i;
   assign last_word = (idx_q == len_q - ADDR_W'(1));
   assign launch    = (state_q == IDLE) && start_i;
   assign seed_eff  = (seed_i == '0) ? SEED_DEFAULT : seed_i;
   assign lfsr_seed = (state_q == IDLE) ? seed_eff : seed_q;
   assign lfsr_load = launch || ((state_q == WR) && accept && last_word);
   assign mismatch  = tag_v_q[RD_LAT-1] && (data_s2f_r_i != tag_exp_q[RD_LAT-1]);

   sram_lfsr16 u_lfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (lfsr_load),
      .step_i (accept),
      .seed_i (lfsr_seed),
      .q_o    (lfsr_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         base_q    <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         err_cnt_q <= '0;
         addr_q    <= '0;
         seed_q    <= '0;
         data_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         mem_q     <= 1'b0;
         rw_q      <= 1'b0;
         tag_v_q   <= '0;
         for (int k = 0; k < RD_LAT; k++) tag_exp_q[k] <= '0;
      end else begin
         done_q <= 1'b0;
         // Expected word rides alongside the read so it lines up with the returned data.
         tag_v_q      <= {tag_v_q[RD_LAT-2:0], (state_q == RD) && accept};
         tag_exp_q[0] <= lfsr_q;
         for (int k = 1; k < RD_LAT; k++) tag_exp_q[k] <= tag_exp_q[k-1];
         if (mismatch) err_cnt_q <= sat_inc(err_cnt_q);

         case (state_q)
            IDLE: begin
               if (start_i) begin
                  base_q    <= base_addr_i;
                  len_q     <= len_i;
                  seed_q    <= seed_eff;
                  idx_q     <= '0;
                  err_cnt_q <= '0;
                  pass_q    <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= (len_i == '0) ? FIN : WR;
               end
            end
            WR, RD: begin
               if (mem_q) begin
                  if (ready_i) begin
                     mem_q <= 1'b0;
                     idx_q <= last_word ? '0 : idx_q + ADDR_W'(1);
                     if (last_word) state_q <= (state_q == WR) ? RD : DRAIN;
                  end
               end else begin
                  mem_q  <= 1'b1;
                  rw_q   <= (state_q == RD);
                  addr_q <= base_q + idx_q;
                  if (state_q == WR) data_q <= lfsr_q;
               end
            end
            DRAIN: begin
               if (tag_v_q[RD_LAT-2:0] == '0) state_q <= FIN;
            end
            FIN: begin
               done_q  <= 1'b1;
               pass_q  <= (err_cnt_q == '0);
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef SRAM_TEST_ERRLOG_EN
   logic [ADDR_W-1:0] tag_addr_q [RD_LAT];
   logic [ADDR_W-1:0] fail_addr_q;
   logic [DATA_W-1:0] fail_exp_q, fail_act_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < RD_LAT; k++) tag_addr_q[k] <= '0;
         fail_addr_q <= '0;
         fail_exp_q  <= '0;
         fail_act_q  <= '0;
      end else begin
         tag_addr_q[0] <= addr_q;
         for (int k = 1; k < RD_LAT; k++) tag_addr_q[k] <= tag_addr_q[k-1];
         if (launch) begin
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
         end else if (mismatch && (err_cnt_q == '0)) begin
            fail_addr_q <= tag_addr_q[RD_LAT-1];
            fail_exp_q  <= tag_exp_q[RD_LAT-1];
            fail_act_q  <= data_s2f_r_i;
         end
      end
   end

   assign fail_addr_o = fail_addr_q;
   assign fail_exp_o  = fail_exp_q;
   assign fail_act_o  = fail_act_q;
`else
   assign fail_addr_o = '0;
   assign fail_exp_o  = '0;
   assign fail_act_o  = '0;
`endif

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign pass_o     = pass_q;
   assign err_cnt_o  = err_cnt_q;
   assign mem_o      = mem_q;
   assign rw_o       = rw_q;
   assign addr_o     = addr_q;
   assign data_f2s_o = data_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_test_seq.sv
// tb_sram_test_seq: directed checks of sram_test_seq against a 2-cycle-busy SRAM controller model.
`timescale 1ns/1ps
`default_nettype none

module tb_sram_test_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic        ready_i = 1'b0;
   logic [15:0] seed_i = '0;
   logic [17:0] base_addr_i = '0;
   logic [17:0] len_i = '0;
   logic [15:0] data_s2f_r_i = 16'hDEAD;
   logic        busy_o, done_o, pass_o, mem_o, rw_o;
   logic [17:0] err_cnt_o, addr_o, fail_addr_o;
   logic [15:0] data_f2s_o, fail_exp_o, fail_act_o;

   sram_test_seq dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .seed_i       (seed_i),
      .base_addr_i  (base_addr_i),
      .len_i        (len_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .pass_o       (pass_o),
      .err_cnt_o    (err_cnt_o),
      .mem_o        (mem_o),
      .rw_o         (rw_o),
      .addr_o       (addr_o),
      .data_f2s_o   (data_f2s_o),
      .ready_i      (ready_i),
      .data_s2f_r_i (data_s2f_r_i),
      .fail_addr_o  (fail_addr_o),
      .fail_exp_o   (fail_exp_o),
      .fail_act_o   (fail_act_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   int          cyc_n = 0, busy_cnt = 0, rd_words = 0, flip_idx = -1;
   int          done_cnt = 0, done_cyc = 0, start_cyc = 0, mem_cyc = 0;
   int          gap_viol = 0, hold_viol = 0;
   logic        prev_acc = 1'b0, prev_pend = 1'b0;
   logic [34:0] prev_req = '0;
   logic [15:0] sram [int];
   logic [15:0] rdq [int];
   logic [17:0] wr_addr_q [$];
   logic [17:0] rd_addr_q [$];
   logic [15:0] wr_data_q [$];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] q);
      return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
   endfunction

   function automatic logic [15:0] pattern(input logic [15:0] seed, input int n);
      logic [15:0] p = (seed == 16'h0) ? 16'hACE1 : seed;
      for (int i = 0; i < n; i++) p = lfsr_next(p);
      return p;
   endfunction

   // One clock of the controller model, evaluated mid-cycle while DUT outputs are stable.
   task automatic cyc();
      logic acc;
      @(negedge clk);
      cyc_n++;
      ready_i = (busy_cnt == 0);
      if (rdq.exists(cyc_n)) begin
         data_s2f_r_i = rdq[cyc_n];
         rdq.delete(cyc_n);
      end else begin
         data_s2f_r_i = 16'hDEAD;
      end
      if (done_o) begin
         done_cnt++;
         done_cyc = cyc_n;
      end
      if (mem_o) mem_cyc++;
      if (prev_acc && mem_o) gap_viol++;
      if (prev_pend && !(mem_o && ({rw_o, addr_o, data_f2s_o} == prev_req))) hold_viol++;
      acc = mem_o && ready_i;
      if (acc) begin
         if (rw_o) begin
            rdq[cyc_n + 3] = (sram.exists(int'(addr_o)) ? sram[int'(addr_o)] : 16'h0)
                             ^ ((rd_words == flip_idx) ? 16'h1 : 16'h0);
            rd_addr_q.push_back(addr_o);
            rd_words++;
         end else begin
            sram[int'(addr_o)] = data_f2s_o;
            wr_addr_q.push_back(addr_o);
            wr_data_q.push_back(data_f2s_o);
         end
         busy_cnt = 2;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
      end
      prev_acc  = acc;
      prev_pend = mem_o && !ready_i;
      prev_req  = {rw_o, addr_o, data_f2s_o};
   endtask

   task automatic launch(input logic [15:0] s, input logic [17:0] b, input logic [17:0] l,
                         input int flip);
      wr_addr_q.delete();
      rd_addr_q.delete();
      wr_data_q.delete();
      flip_idx = flip;
      rd_words = 0;
      done_cnt = 0;
      mem_cyc  = 0;
      cyc();
      seed_i = s;
      base_addr_i = b;
      len_i = l;
      start_i = 1'b1;
      start_cyc = cyc_n;
      cyc();
      start_i = 1'b0;
      seed_i = 16'hFFFF;
      base_addr_i = 18'h2AAAA;
      len_i = 18'd5;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         cyc();
         n++;
      end
      chk("done_seen", done_cnt != 0, 1);
      repeat (3) cyc();
      chk("done_single", done_cnt, 1);
   endtask

   task automatic chk_words(input logic [15:0] s, input logic [17:0] b, input int l);
      logic [15:0] p = (s == 16'h0) ? 16'hACE1 : s;
      logic [17:0] a;
      chk("wr_count", wr_addr_q.size(), l);
      chk("rd_count", rd_addr_q.size(), l);
      for (int i = 0; i < l; i++) begin
         a = b + 18'(i);
         if (i < wr_addr_q.size()) begin
            chk("wr_addr", wr_addr_q[i], a);
            chk("wr_data", wr_data_q[i], p);
         end
         if (i < rd_addr_q.size()) chk("rd_addr", rd_addr_q[i], a);
         p = lfsr_next(p);
      end
   endtask

   task automatic chk_rst();
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_pass", pass_o, 0);
      chk("rst_err", err_cnt_o, 0);
      chk("rst_mem", mem_o, 0);
      chk("rst_rw", rw_o, 0);
      chk("rst_addr", addr_o, 0);
      chk("rst_data", data_f2s_o, 0);
      chk("rst_log", {fail_addr_o, fail_exp_o, fail_act_o}, 0);
   endtask

   initial begin
      repeat (3) cyc();
      chk_rst();
      rst_n = 1'b1;
      cyc();

      // Clean 8-word run.
      launch(16'h1234, 18'h0, 18'd8, -1);
      wait_done(500);
      chk("t1_pass", pass_o, 1);
      chk("t1_err", err_cnt_o, 0);
      chk("t1_busy_after", busy_o, 0);
      chk("t1_word1", pattern(16'h1234, 1), 16'h2469);
      chk_words(16'h1234, 18'h0, 8);

      // Single-bit corruption on read of word 5.
      launch(16'h1234, 18'h0, 18'd8, 5);
      wait_done(500);
      chk("t2_pass", pass_o, 0);
      chk("t2_err", err_cnt_o, 1);
`ifdef SRAM_TEST_ERRLOG_EN
      chk("t2_fail_addr", fail_addr_o, 18'd5);
      chk("t2_fail_exp", fail_exp_o, pattern(16'h1234, 5));
      chk("t2_fail_act", fail_act_o, fail_exp_o ^ 16'h1);
`else
      chk("t2_fail_log", {fail_addr_o, fail_exp_o, fail_act_o}, 0);
`endif

      // Address wrap at the top of the space.
      launch(16'h00F0, 18'h3FFFE, 18'd4, -1);
      wait_done(500);
      chk("t3_pass", pass_o, 1);
      chk_words(16'h00F0, 18'h3FFFE, 4);
      chk("t3_wrap_addr2", wr_addr_q.size() > 2 ? wr_addr_q[2] : 18'h3FFFF, 18'h00000);

      // Zero-length run.
      launch(16'h4321, 18'h77, 18'd0, -1);
      wait_done(50);
      chk("t4_latency", done_cyc - start_cyc, 2);
      chk("t4_no_mem", mem_cyc, 0);
      chk("t4_pass", pass_o, 1);

      // Zero seed falls back to the default seed.
      launch(16'h0000, 18'h10, 18'd2, -1);
      wait_done(200);
      chk("t5_pass", pass_o, 1);
      chk("t5_word0", wr_data_q.size() > 0 ? wr_data_q[0] : 16'h0, 16'hACE1);
      chk("t5_word1", wr_data_q.size() > 1 ? wr_data_q[1] : 16'h0, 16'h59C3);

      // Reset during the read phase of a long run.
      launch(16'hBEEF, 18'h1000, 18'd100, -1);
      begin
         int n = 0;
         while (rd_addr_q.size() < 10 && n < 2000) begin
            cyc();
            n++;
         end
      end
      chk("t6_in_rd", rd_addr_q.size() >= 10, 1);
      #1 rst_n = 1'b0;
      #1 chk_rst();
      rdq.delete();
      busy_cnt = 0;
      prev_acc = 1'b0;
      prev_pend = 1'b0;
      done_cnt = 0;
      repeat (2) cyc();
      rst_n = 1'b1;
      repeat (30) cyc();
      chk("t6_no_done", done_cnt, 0);
      chk("t6_idle_mem", mem_cyc > 0 ? mem_o : 1'b0, 0);
      launch(16'h0BAD, 18'h20, 18'd3, -1);
      wait_done(200);
      chk("t6_rerun_pass", pass_o, 1);
      chk_words(16'h0BAD, 18'h20, 3);

      // Start pulses while busy are ignored.
      launch(16'h5555, 18'h100, 18'd4, -1);
      repeat (4) cyc();
      seed_i = 16'h9999;
      base_addr_i = 18'h200;
      len_i = 18'd1;
      start_i = 1'b1;
      cyc();
      start_i = 1'b0;
      wait_done(500);
      chk("t7_pass", pass_o, 1);
      chk_words(16'h5555, 18'h100, 4);

      chk("gap_viol", gap_viol, 0);
      chk("hold_viol", hold_viol, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
